// File: rtl/rmii_frame_tx.sv
// rtl/rmii_frame_tx.sv - RMII transmitter: byte stream to framed txen/txd dibits
//
// Serializes a payload byte stream (dest MAC + src MAC + ethertype + data)
// onto RMII as preamble, SFD, payload, zero pad, optional FCS, then the
// interframe gap. Two bits per clk, LSB dibit first.
//
// Optional feature macro: RMII_TX_FCS_EN (CRC-32 generator and 4-byte FCS).
//
// Parameters:
//   IFG_BYTES   - interframe gap in byte times (4 clk each), >= 1
//   MIN_PAYLOAD - bytes before FCS; shorter frames are zero padded; 0 = no pad
// Ports:
//   clk        - 50 MHz RMII reference clock
//   rst        - synchronous reset, active high
//   data_in    - payload byte
//   valid_in   - data_in / last_in valid
//   last_in    - data_in is the final payload byte
//   ready_out  - byte consumed this cycle when valid_in & ready_out
//   txen, txd  - RMII transmit enable and dibit
//   busy       - high from frame start through end of the gap
//   underrun   - one-cycle pulse: byte needed but valid_in low
module rmii_frame_tx #(
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       last_in,
  output logic       ready_out,
  output logic       txen,
  output logic [1:0] txd,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  // The gap includes the IDLE cycle that samples the next frame's valid_in,
  // so the IFG state itself lasts one cycle less than the full gap.
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES * 4 - 2);

  state_t      state;
  logic [1:0]  dcnt;      // dibit index of the byte currently on txd
  logic [5:0]  sh;        // remaining dibits of the current byte
  logic [2:0]  bcnt;      // byte index within preamble / FCS
  logic [15:0] pay_cnt;   // payload + pad bytes sent, saturating
  logic [15:0] ifg_cnt;
  logic        cur_last;  // current payload byte was flagged last

  // Decision taken at the last dibit of a byte: what the next byte is.
  state_t      nb_state;
  logic [7:0]  nb_byte;
  logic        nb_load;
  logic        nb_accept;
  logic        need_pad;

  assign need_pad = (17'(pay_cnt) + 17'd1) <= 17'(MIN_PAYLOAD);
  assign underrun = ready_out & ~valid_in;

`ifdef RMII_TX_FCS_EN
  logic [31:0] crc;
  logic [31:0] fcs;

  assign fcs = ~crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  always_comb begin
    nb_state  = state;
    nb_byte   = 8'h00;
    nb_load   = 1'b0;
    nb_accept = 1'b0;
    case (state)
      S_PRE: begin
        nb_load = 1'b1;
        if (bcnt == 3'd6) begin
          nb_state = S_SFD;
          nb_byte  = 8'hD5;
        end else begin
          nb_byte = 8'h55;
        end
      end
      S_SFD, S_PAYLOAD, S_PAD: begin
        if (ready_out) begin
          if (valid_in) begin
            nb_state  = S_PAYLOAD;
            nb_byte   = data_in;
            nb_load   = 1'b1;
            nb_accept = 1'b1;
          end else begin
            nb_state = S_IFG;   // underrun: abandon the frame, no FCS
          end
        end else if (need_pad) begin
          nb_state = S_PAD;
          nb_load  = 1'b1;
        end else begin
`ifdef RMII_TX_FCS_EN
          nb_state = S_FCS;
          nb_byte  = fcs[7:0];
          nb_load  = 1'b1;
`else
          nb_state = S_IFG;
`endif
        end
      end
`ifdef RMII_TX_FCS_EN
      S_FCS: begin
        if (bcnt == 3'd3) begin
          nb_state = S_IFG;
        end else begin
          nb_byte = fcs[{bcnt[1:0] + 2'd1, 3'b000} +: 8];
          nb_load = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dcnt      <= 2'd0;
      sh        <= 6'd0;
      bcnt      <= 3'd0;
      pay_cnt   <= 16'd0;
      ifg_cnt   <= 16'd0;
      cur_last  <= 1'b0;
      txen      <= 1'b0;
      txd       <= 2'b00;
      ready_out <= 1'b0;
      busy      <= 1'b0;
`ifdef RMII_TX_FCS_EN
      crc       <= 32'hFFFFFFFF;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            state   <= S_PRE;
            txen    <= 1'b1;
            busy    <= 1'b1;
            txd     <= 2'b01;       // 8'h55 dibit 0
            sh      <= 6'b010101;   // 8'h55 dibits 1..3
            dcnt    <= 2'd0;
            bcnt    <= 3'd0;
            pay_cnt <= 16'd0;
`ifdef RMII_TX_FCS_EN
            crc     <= 32'hFFFFFFFF;
`endif
          end
        end
        S_IFG: begin
          if (ifg_cnt == IFG_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            ifg_cnt <= ifg_cnt + 16'd1;
          end
        end
        default: begin
          if (dcnt != 2'd3) begin
            dcnt      <= dcnt + 2'd1;
            txd       <= sh[1:0];
            sh        <= {2'b00, sh[5:2]};
            // Request the next byte on dibit 3 so it follows without a bubble.
            ready_out <= (dcnt == 2'd2) &&
                         (state == S_SFD || (state == S_PAYLOAD && !cur_last));
          end else begin
            ready_out <= 1'b0;
            state     <= nb_state;
            bcnt      <= (nb_state == state) ? bcnt + 3'd1 : 3'd0;
            dcnt      <= 2'd0;
            if (nb_accept)
              cur_last <= last_in;
            if (nb_load) begin
              txd <= nb_byte[1:0];
              sh  <= nb_byte[7:2];
              if (nb_state == S_PAYLOAD || nb_state == S_PAD) begin
                if (pay_cnt != 16'hFFFF)
                  pay_cnt <= pay_cnt + 16'd1;
`ifdef RMII_TX_FCS_EN
                crc <= crc_byte(crc, nb_byte);
`endif
              end
            end else begin
              txen    <= 1'b0;
              txd     <= 2'b00;
              ifg_cnt <= 16'd0;
            end
          end
        end
      endcase
    end
  end

endmodule
